// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types, register map and priority helper for int_ctrl
package int_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, STOP, CALL, JMP} state_e;

  localparam logic [2:0] REG_MASK = 3'd0;
  localparam logic [2:0] REG_MODE = 3'd1;
  localparam logic [2:0] REG_PEND = 3'd2;
  localparam logic [2:0] REG_ISR  = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;

  // Index of the lowest set bit; 16 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [15:0] v);
    lowest_set = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - two-flop synchroniser with rising-edge detect for the raw irq lines
module int_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] sync,
  output logic [N-1:0] rise
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;
  logic [N-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - vectored interrupt controller with mask, edge/level mode,
// fixed priority nesting and stop/call/jump handshake to the core
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int                N_IRQ      = 8,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(16'h0010),
  parameter int                VEC_STRIDE = 4
) (
  input  logic              clk_bus,
  input  logic              rst_bus,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  input  logic              core_ready,
  input  logic              reti,
  output logic              int_stop,
  output logic              int_call,
  output logic              int_jmp,
  output logic [ADDR_W-1:0] int_addr,
  output logic [3:0]        int_id
);

  logic [N_IRQ-1:0] s_irq, rise;
  logic [N_IRQ-1:0] mask_q, mask_d, mode_q, mode_d;
  logic [N_IRQ-1:0] pend_q, pend_d, isr_q, isr_d;
  logic             gie_q, gie_d;
  logic [N_IRQ-1:0] below, elig, w1c, take_clr;
  logic [4:0]       isr_lo, win;
  logic             any_elig;
  logic [ADDR_W-1:0] vec_addr;

  state_e            state_q;
  logic              int_stop_q, int_call_q, int_jmp_q;
  logic [ADDR_W-1:0] int_addr_q;
  logic [3:0]        int_id_q;

  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  int_sync #(.N(N_IRQ)) u_sync (
    .clk   (clk_bus),
    .rst_n (rst_bus),
    .din   (irq),
    .sync  (s_irq),
    .rise  (rise)
  );

  // Only lines strictly above the highest-priority in-service line may preempt.
  always_comb begin
    below  = '0;
    isr_lo = lowest_set(16'(isr_q));
    for (int i = 0; i < N_IRQ; i++) begin
      below[i] = (i < int'(isr_lo));
    end
    elig = pend_q & mask_q & below & {N_IRQ{gie_q}};
    win  = lowest_set(16'(elig));
  end

  assign any_elig = !win[4];
  assign vec_addr = VEC_BASE + ADDR_W'(win[3:0]) * ADDR_W'(VEC_STRIDE);

  always_comb begin
    mask_d   = mask_q;
    mode_d   = mode_q;
    gie_d    = gie_q;
    w1c      = '0;
    take_clr = '0;
    if (cfg_we) begin
      case (cfg_addr)
        REG_MASK: mask_d = cfg_wdata[N_IRQ-1:0];
        REG_MODE: mode_d = cfg_wdata[N_IRQ-1:0];
        REG_PEND: w1c    = cfg_wdata[N_IRQ-1:0];
        REG_CTRL: gie_d  = cfg_wdata[0];
        default: ;
      endcase
    end
    // reti clears before the CALL sets, so both may land in one cycle.
    isr_d = isr_q;
    if (reti) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (i == int'(isr_lo)) isr_d[i] = 1'b0;
      end
    end
    if (state_q == CALL) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (i == int'(int_id_q)) begin
          isr_d[i]    = 1'b1;
          take_clr[i] = mode_q[i];
        end
      end
    end
    pend_d = (mode_q & ((pend_q & ~w1c & ~take_clr) | rise)) | (~mode_q & s_irq);
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      gie_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      gie_q  <= gie_d;
    end
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state_q    <= IDLE;
      int_stop_q <= 1'b0;
      int_call_q <= 1'b0;
      int_jmp_q  <= 1'b0;
      int_addr_q <= '0;
      int_id_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            state_q    <= STOP;
            int_stop_q <= 1'b1;
          end
        end
        STOP: begin
          if (!any_elig) begin
            state_q    <= IDLE;
            int_stop_q <= 1'b0;
          end else if (core_ready) begin
            state_q    <= CALL;
            int_call_q <= 1'b1;
            int_addr_q <= vec_addr;
            int_id_q   <= win[3:0];
          end
        end
        CALL: begin
          state_q    <= JMP;
          int_call_q <= 1'b0;
          int_jmp_q  <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          int_stop_q <= 1'b0;
          int_call_q <= 1'b0;
          int_jmp_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_MASK: cfg_rdata = 16'(mask_q);
      REG_MODE: cfg_rdata = 16'(mode_q);
      REG_PEND: cfg_rdata = 16'(pend_q);
      REG_ISR:  cfg_rdata = 16'(isr_q);
      REG_CTRL: cfg_rdata = {15'd0, gie_q};
      default: ;
    endcase
  end

  assign int_stop = int_stop_q;
  assign int_call = int_call_q;
  assign int_jmp  = int_jmp_q;
  assign int_addr = int_addr_q;
  assign int_id   = int_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl: register table, directed
// corner sequences and a randomized run against a behavioural reference model
module tb_int_ctrl;

  logic        clk_bus = 1'b0;
  logic        rst_bus = 1'b0;
  logic [7:0]  irq = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic        core_ready = 1'b0;
  logic        reti = 1'b0;
  logic        int_stop, int_call, int_jmp;
  logic [15:0] int_addr;
  logic [3:0]  int_id;

  int n_cmp = 0;
  int n_bad = 0;

  int_ctrl dut (
    .clk_bus    (clk_bus),
    .rst_bus    (rst_bus),
    .irq        (irq),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .core_ready (core_ready),
    .reti       (reti),
    .int_stop   (int_stop),
    .int_call   (int_call),
    .int_jmp    (int_jmp),
    .int_addr   (int_addr),
    .int_id     (int_id)
  );

  always #5 clk_bus = ~clk_bus;

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic check_reg(input string nm, input logic [2:0] a, input logic [15:0] exp);
    cfg_addr = a;
    #1;
    check(nm, 32'(cfg_rdata), 32'(exp));
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic expect_take(input string nm, input int id, input logic [15:0] addr);
    int n;
    n = 0;
    while (!int_stop && n < 12) begin tick(); n++; end
    check({nm, "_stop"}, 32'(int_stop), 32'd1);
    core_ready = 1'b1;
    tick();
    check({nm, "_call"}, 32'(int_call), 32'd1);
    check({nm, "_id_call"}, 32'(int_id), 32'(id));
    tick();
    check({nm, "_jmp"}, {int_jmp, int_call}, 32'b10);
    check({nm, "_addr"}, 32'(int_addr), 32'(addr));
    check({nm, "_id"}, 32'(int_id), 32'(id));
    tick();
    check({nm, "_release"}, {int_stop, int_jmp}, 32'b00);
  endtask

  // Behavioural reference: bit-vector arithmetic on the register rules.
  logic [7:0]  m_mask, m_mode, m_pend, m_isr, m_meta, m_s, m_prev;
  logic        m_gie;
  int          m_phase, m_w;
  logic [15:0] m_addr;
  logic [3:0]  m_id;

  task automatic model_reset();
    m_mask = 0; m_mode = 0; m_pend = 0; m_isr = 0; m_gie = 0;
    m_meta = 0; m_s = 0; m_prev = 0;
    m_phase = 0; m_w = 0; m_addr = 0; m_id = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {8'h0, m_mask};
      3'd1: return {8'h0, m_mode};
      3'd2: return {8'h0, m_pend};
      3'd3: return {8'h0, m_isr};
      3'd4: return {15'h0, m_gie};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_step(input logic [7:0] irq_in, input logic we, input logic [2:0] a,
                            input logic [15:0] wd, input logic rdy, input logic rt);
    int isr_i, below, elig, win;
    logic [7:0] rise, w1c, tclr, n_isr;
    isr_i = int'(m_isr);
    below = (isr_i == 0) ? 255 : ((isr_i & -isr_i) - 1);
    elig  = int'(m_pend & m_mask) & below & (m_gie ? 255 : 0);
    win   = (elig == 0) ? 0 : $clog2(elig & -elig);
    rise  = m_s & ~m_prev;
    w1c   = (we && a == 3'd2) ? wd[7:0] : 8'h0;
    tclr  = (m_phase == 2) ? (m_mode & 8'(1 << m_w)) : 8'h0;
    n_isr = m_isr;
    if (rt && n_isr != 0) n_isr = n_isr & (n_isr - 8'd1);
    if (m_phase == 2) n_isr = n_isr | 8'(1 << m_w);
    m_pend = (m_mode & ((m_pend & ~w1c & ~tclr) | rise)) | (~m_mode & m_s);
    m_isr  = n_isr;
    case (m_phase)
      0: if (elig != 0) m_phase = 1;
      1: begin
        if (elig == 0) m_phase = 0;
        else if (rdy) begin
          m_phase = 2; m_w = win; m_id = 4'(win);
          m_addr = 16'(32'h10 + 4 * win);
        end
      end
      2: m_phase = 3;
      default: m_phase = 0;
    endcase
    if (we) begin
      case (a)
        3'd0: m_mask = wd[7:0];
        3'd1: m_mode = wd[7:0];
        3'd4: m_gie  = wd[0];
        default: ;
      endcase
    end
    m_prev = m_s; m_s = m_meta; m_meta = irq_in;
  endtask

  initial begin
    int n;
    logic seen, seen_call;
    logic [15:0] v;

    vecs[0] = '{"reg_mask",  3'd0, 16'hFFFF, 16'h00FF};
    vecs[1] = '{"reg_mode",  3'd1, 16'hA5A5, 16'h00A5};
    vecs[2] = '{"reg_ctrl0", 3'd4, 16'hFFFE, 16'h0000};
    vecs[3] = '{"reg_ctrl1", 3'd4, 16'h0003, 16'h0001};
    vecs[4] = '{"reg_pend",  3'd2, 16'hFFFF, 16'h0000};
    vecs[5] = '{"reg_isr",   3'd3, 16'hFFFF, 16'h0000};
    vecs[6] = '{"reg_addr5", 3'd5, 16'hFFFF, 16'h0000};
    vecs[7] = '{"reg_addr7", 3'd7, 16'h1234, 16'h0000};

    #23;
    check("rst_outputs", {int_stop, int_call, int_jmp, int_addr, int_id}, 32'h0);
    @(negedge clk_bus) rst_bus = 1'b1;
    tick();
    for (int a = 0; a < 5; a++) check_reg("rst_reg", 3'(a), 16'h0);

    for (int i = 0; i < 8; i++) begin
      cfg_write(vecs[i].addr, vecs[i].wdata);
      check_reg(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Basic take on line 3
    cfg_write(3'd0, 16'h0008);
    cfg_write(3'd1, 16'h0008);
    cfg_write(3'd4, 16'h0001);
    core_ready = 1'b1;
    irq = 8'h08;
    tick(); n = 1;
    irq = 8'h00;
    while (!int_stop && n < 8) begin tick(); n++; end
    check("basic_latency_le4", 32'(int_stop && n <= 4), 32'd1);
    expect_take("basic", 3, 16'h001C);
    check_reg("basic_pend", 3'd2, 16'h0000);
    check_reg("basic_isr", 3'd3, 16'h0008);
    pulse_reti();
    check_reg("basic_reti_isr", 3'd3, 16'h0000);

    // Priority: 2 before 5, 5 after reti
    cfg_write(3'd0, 16'h0024);
    cfg_write(3'd1, 16'h0024);
    core_ready = 1'b0;
    pulse_irq(8'h24);
    expect_take("prio_2", 2, 16'h0018);
    seen = 1'b0;
    repeat (5) begin tick(); if (int_stop) seen = 1'b1; end
    check("prio_5_blocked", 32'(seen), 32'd0);
    pulse_reti();
    expect_take("prio_5", 5, 16'h0024);
    pulse_reti();

    // Nesting: 4, then 1 preempts, 6 waits for both returns
    cfg_write(3'd0, 16'h0052);
    cfg_write(3'd1, 16'h0052);
    core_ready = 1'b0;
    pulse_irq(8'h10);
    expect_take("nest_4", 4, 16'h0020);
    pulse_irq(8'h02);
    expect_take("nest_1", 1, 16'h0014);
    check_reg("nest_isr", 3'd3, 16'h0012);
    pulse_irq(8'h40);
    seen = 1'b0;
    repeat (8) begin tick(); if (int_stop) seen = 1'b1; end
    check("nest_6_blocked_a", 32'(seen), 32'd0);
    pulse_reti();
    repeat (6) begin tick(); if (int_stop) seen = 1'b1; end
    check("nest_6_blocked_b", 32'(seen), 32'd0);
    check_reg("nest_isr_after1", 3'd3, 16'h0010);
    pulse_reti();
    expect_take("nest_6", 6, 16'h0028);
    check_reg("nest_isr_6", 3'd3, 16'h0040);
    pulse_reti();
    check_reg("nest_isr_end", 3'd3, 16'h0000);

    // Level line 7 withdrawn while held in STOP
    cfg_write(3'd0, 16'h0080);
    cfg_write(3'd1, 16'h0000);
    core_ready = 1'b0;
    irq = 8'h80;
    n = 0;
    while (!int_stop && n < 10) begin tick(); n++; end
    check("wd_stop", 32'(int_stop), 32'd1);
    seen_call = 1'b0;
    repeat (5) begin tick(); if (int_call) seen_call = 1'b1; end
    check("wd_hold", 32'(int_stop), 32'd1);
    irq = 8'h00;
    n = 0;
    while (int_stop && n < 10) begin tick(); n++; if (int_call) seen_call = 1'b1; end
    check("wd_stop_low", 32'(int_stop), 32'd0);
    core_ready = 1'b1;
    repeat (3) begin tick(); if (int_call || int_stop) seen_call = 1'b1; end
    check("wd_no_call", 32'(seen_call), 32'd0);

    // W1C against a simultaneous edge on line 0
    cfg_write(3'd0, 16'h0000);
    cfg_write(3'd1, 16'h0001);
    irq = 8'h01;
    tick();
    tick();
    cfg_write(3'd2, 16'h0001);
    check_reg("w1c_conflict", 3'd2, 16'h0001);
    cfg_write(3'd2, 16'h0001);
    check_reg("w1c_clear", 3'd2, 16'h0000);
    cfg_write(3'd1, 16'h0000);
    tick();
    cfg_write(3'd2, 16'h0001);
    check_reg("w1c_level_ignored", 3'd2, 16'h0001);
    irq = 8'h00;
    repeat (4) tick();

    // Reset asserted during CALL
    cfg_write(3'd0, 16'h0001);
    cfg_write(3'd1, 16'h0001);
    cfg_write(3'd4, 16'h0001);
    core_ready = 1'b0;
    pulse_irq(8'h01);
    n = 0;
    while (!int_stop && n < 10) begin tick(); n++; end
    core_ready = 1'b1;
    tick();
    check("rstmid_call", 32'(int_call), 32'd1);
    #2 rst_bus = 1'b0;
    #1 check("rstmid_outputs", {int_stop, int_call, int_jmp, int_addr, int_id}, 32'h0);
    @(negedge clk_bus) rst_bus = 1'b1;
    core_ready = 1'b0;
    tick();
    for (int a = 0; a < 5; a++) check_reg("rstmid_reg", 3'(a), 16'h0);

    // Randomized run against the reference model
    rst_bus = 1'b0;
    irq = '0; reti = 1'b0; cfg_we = 1'b0; core_ready = 1'b0;
    #12;
    @(negedge clk_bus) rst_bus = 1'b1;
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i < 3) begin
        cfg_we = 1'b1;
        cfg_addr = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : 3'd4;
        cfg_wdata = (i == 0) ? 16'h00FF : (i == 1) ? 16'h00F0 : 16'h0001;
      end else begin
        cfg_we = ($urandom_range(0, 15) == 0);
        cfg_addr = 3'($urandom_range(0, 7));
        cfg_wdata = 16'($urandom);
        if (cfg_we && cfg_addr == 3'd4 && $urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) irq = irq ^ 8'(1 << $urandom_range(0, 7));
      core_ready = ($urandom_range(0, 1) == 1);
      reti = ($urandom_range(0, 11) == 0);
      model_step(irq, cfg_we, cfg_addr, cfg_wdata, core_ready, reti);
      tick();
      check("rnd_stop", 32'(int_stop), 32'(m_phase != 0));
      check("rnd_call", 32'(int_call), 32'(m_phase == 2));
      check("rnd_jmp", 32'(int_jmp), 32'(m_phase == 3));
      check("rnd_addr", 32'(int_addr), 32'(m_addr));
      check("rnd_id", 32'(int_id), 32'(m_id));
      v = m_read(cfg_addr);
      check("rnd_rdata", 32'(cfg_rdata), 32'(v));
    end
    cfg_we = 1'b0; reti = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised vectored interrupt controller; next generation of the fixed 8-line interrupt unit feeding the CPU control unit and stack.
- Adds per-line mask, edge/level mode, pending/in-service tracking, fixed priority with nesting, and a return-from-interrupt input.
- Configured through a small register port on the data bus.
- Drives the stop / call / jump handshake to UC, PC and stack.

Parameters:
- N_IRQ, 8, number of interrupt lines (1..16); line 0 has the highest priority.
- ADDR_W, 16, vector address width.
- VEC_BASE, 16'h0010, vector address of line 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- clk_bus  in  1  system clock.
- rst_bus  in  1  asynchronous active-low reset.
- irq  in  N_IRQ  raw interrupt lines, asynchronous to clk_bus.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  3  register select.
- cfg_wdata  in  16  write data.
- cfg_rdata  out  16  read data, combinational from cfg_addr.
- core_ready  in  1  core at an instruction boundary, may be diverted.
- reti  in  1  one-cycle pulse, return-from-interrupt executed.
- int_stop  out  1  request to UC to hold the current instruction.
- int_call  out  1  one-cycle pulse, stack pushes the return address.
- int_jmp  out  1  one-cycle pulse, PC loads int_addr.
- int_addr  out  ADDR_W  vector of the line being taken.
- int_id  out  4  index of the line being taken.

Behaviour:
- Reset (rst_bus=0, any time, including mid-sequence): every output is 0, state=IDLE, and MASK, MODE, PENDING, ISR and GIE are all 0.
- Input path: each irq bit passes a 2-flop synchroniser to give s_irq.
- Pending, edge mode (MODE[i]=1): a rising edge of s_irq sets PEND[i]; PEND[i] stays set until the line is taken or cleared by W1C.
- Pending, level mode (MODE[i]=0): PEND[i] follows s_irq; it is not latched and W1C has no effect.
- Same-cycle conflict: a hardware set of PEND[i] wins over a W1C clear of PEND[i].
- Registers (cfg_addr):
  - 0 MASK, RW.
  - 1 MODE, RW.
  - 2 PEND, read; write 1 clears the bit.
  - 3 ISR, read-only.
  - 4 CTRL, bit0=GIE.
  - Other addresses read 0 and ignore writes.
  - Bits at and above N_IRQ read 0.
  - Writes take effect on the next clk_bus edge.
- Eligible set: PEND & MASK & GIE. A line is eligible only if its index is lower than the lowest set ISR bit; when ISR=0, all lines qualify.
- Winner: the lowest-index eligible line.
- State machine:
  - IDLE: if any line is eligible, go to STOP.
  - STOP: int_stop=1. The winner is re-evaluated every cycle. If no line is eligible, return to IDLE (int_stop drops next cycle). If core_ready=1, latch the winner and go to CALL.
  - CALL: int_stop=1 and int_call=1. Set ISR[w]. Clear PEND[w] if the line is in edge mode. Go to JMP.
  - JMP: int_stop=1, int_jmp=1, int_addr=VEC_BASE+w*VEC_STRIDE, int_id=w. Go to IDLE.
- Timing: int_addr and int_id are held from CALL until the next CALL. From an irq edge to int_stop high takes 4 clk_bus edges at most (2 sync, 1 pending, 1 state).
- reti: clears the lowest set ISR bit. When ISR=0, reti is ignored. If reti arrives in the same cycle as CALL, the clear is applied first, then ISR[w] is set.
- Nesting: the depth is bounded by N_IRQ, so there is no overflow case. A line that is already in service cannot re-enter until it is cleared by reti.
- Width rule: vector arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W.

Decomposition:
- Package int_ctrl_pkg holds:
  - the state enum (IDLE, STOP, CALL, JMP);
  - the register address constants;
  - a function that returns the lowest set bit index of a 16-bit vector (used for both winner and ISR).
- One sub-module, int_sync, implements the N-bit 2-flop synchroniser plus the rising-edge detector.

Test Plan:
- Basic take: MASK=0x08, MODE=0x08, GIE=1; pulse irq[3]; hold core_ready=1 -> int_stop within 4 cycles, int_call one cycle, then int_jmp with int_addr=0x001C and int_id=3; PEND=0 and ISR=0x08 afterwards.
- Priority: with irq[5] and irq[2] pending together -> line 2 is taken (int_addr=0x0018); after reti, line 5 is taken (int_addr=0x0024).
- Nesting: line 4 is in service and irq[1] fires -> line 1 preempts and ISR=0x12; irq[6] firing meanwhile is blocked until both reti pulses are done.
- Mask and withdraw: level line 7 is asserted and held in STOP with core_ready=0; then irq[7] drops -> return to IDLE, int_stop low, and no int_call.
- W1C conflict: write PEND=0x01 in the same cycle as an irq[0] edge -> PEND[0] reads 1.
- Reset mid-sequence: drive rst_bus=0 during CALL -> all outputs 0 immediately, and registers read 0 after release.
